mem_ctrl: RTL and testbench

- Memory-side stage directly downstream of the multicycle core.
- Consumes the core's level-held request (wen, mode, addr, store data) and converts it to a single-port synchronous SRAM access. Stores get byte-lane strobes and lane-shifted data; loads get lane extraction plus sign/zero extension.
- Returns data and a ready flag to the core.
- The core side has no request strobe: a new access is started whenever the request tuple changes.

---
 rtl/mem_ctrl.sv | 164 ++++++++++++++++
 tb/tb_mem_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Memory-side stage between the multicycle core and a single-port synchronous SRAM.
// Turns a level-held core request into one SRAM access, with store lane steering and load extension.
module mem_ctrl #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  core_wen,
  input  logic [2:0]            core_mode,
  input  logic [31:0]           core_addr,
  input  logic [31:0]           core_wdata,
  output logic [31:0]           core_rdata,
  output logic                  core_ready,
  output logic                  misalign_err,
  output logic                  sram_ce,
  output logic                  sram_we,
  output logic [3:0]            sram_be,
  output logic [ADDR_WIDTH-3:0] sram_addr,
  output logic [31:0]           sram_wdata,
  input  logic [31:0]           sram_rdata
);

  localparam int unsigned KeyW = 68;
  localparam logic [2:0] CntInit = 3'(RD_LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e          state_q, state_d;
  logic [KeyW-1:0] key, last_key_q, last_key_d;
  logic            key_valid_q, key_valid_d;
  logic            ready_q, ready_d;
  logic            misalign_q, misalign_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [1:0]      off_q, off_d;
  logic [2:0]      mode_q, mode_d;

  logic        pending, is_byte, is_half, is_word, misaligned, issue;
  logic [31:0] lane, load_val;

  assign key     = {core_wen, core_mode, core_addr, core_wdata};
  assign pending = ~key_valid_q | (key != last_key_q);

  assign is_byte    = (core_mode[1:0] == 2'b00);
  assign is_half    = (core_mode[1:0] == 2'b01);
  assign is_word    = core_mode[1];
  assign misaligned = (is_half & core_addr[0]) | (is_word & (core_addr[1:0] != 2'b00));

  // Lane extraction uses the mode/offset latched at issue, not the live request.
  always_comb begin
    lane     = sram_rdata >> {off_q, 3'b000};
    load_val = sram_rdata;
    unique case (mode_q[1:0])
      2'b00:   load_val = {{24{lane[7] & ~mode_q[2]}}, lane[7:0]};
      2'b01:   load_val = {{16{lane[15] & ~mode_q[2]}}, lane[15:0]};
      default: load_val = sram_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    last_key_d  = last_key_q;
    key_valid_d = key_valid_q;
    ready_d     = ready_q;
    misalign_d  = misalign_q;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;
    off_d       = off_q;
    mode_d      = mode_q;
    issue       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pending) begin
          last_key_d  = key;
          key_valid_d = 1'b1;
          ready_d     = 1'b0;
          if (misaligned) begin
            misalign_d = 1'b1;
            rdata_d    = '0;
            state_d    = StDone;
          end else begin
            issue      = 1'b1;
            misalign_d = 1'b0;
            off_d      = core_addr[1:0];
            mode_d     = core_mode;
            if (core_wen) begin
              state_d = StDone;
            end else begin
              cnt_d   = CntInit;
              state_d = StWait;
            end
          end
        end
      end
      StWait: begin
        if (cnt_q == 3'd0) begin
          rdata_d = load_val;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StDone: begin
        ready_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Gated by rst so the SRAM sees no strobe while reset holds the FSM in IDLE with key_valid low.
  always_comb begin
    sram_ce    = issue & rst;
    sram_we    = sram_ce & core_wen;
    sram_be    = '0;
    sram_wdata = '0;
    sram_addr  = '0;
    if (sram_ce) begin
      sram_addr = core_addr[ADDR_WIDTH-1:2];
      sram_be   = 4'b1111;
      if (core_wen) begin
        if (is_byte) begin
          sram_be    = 4'b0001 << core_addr[1:0];
          sram_wdata = {4{core_wdata[7:0]}};
        end else if (is_half) begin
          sram_be    = 4'b0011 << core_addr[1:0];
          sram_wdata = {2{core_wdata[15:0]}};
        end else begin
          sram_wdata = core_wdata;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      last_key_q  <= '0;
      key_valid_q <= 1'b0;
      ready_q     <= 1'b0;
      misalign_q  <= 1'b0;
      rdata_q     <= '0;
      cnt_q       <= '0;
      off_q       <= '0;
      mode_q      <= '0;
    end else begin
      state_q     <= state_d;
      last_key_q  <= last_key_d;
      key_valid_q <= key_valid_d;
      ready_q     <= ready_d;
      misalign_q  <= misalign_d;
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
      off_q       <= off_d;
      mode_q      <= mode_d;
    end
  end

  assign core_rdata   = rdata_q;
  assign core_ready   = ready_q & ~pending;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: one instance at RD_LATENCY=1, one at RD_LATENCY=3,
// sharing the core-side stimulus and a behavioural SRAM.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wen;
  logic [2:0]  mode;
  logic [31:0] addr, wdata;

  logic [31:0] rdata1, swdata1, srdata1;
  logic        ready1, mis1, ce1, we1;
  logic [3:0]  be1;
  logic [13:0] saddr1;

  logic [31:0] rdata3, swdata3, srdata3;
  logic        ready3, mis3, ce3, we3;
  logic [3:0]  be3;
  logic [13:0] saddr3;

  logic [31:0] mem [256];
  logic [31:0] pipe3 [3];
  logic        pl_en;
  logic [7:0]  pl_idx;
  logic [31:0] pl_val;

  int n_vec = 0;
  int n_miss = 0;
  int ce_cnt1 = 0;
  int ce_cnt3 = 0;
  int n0;

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_WIDTH(16), .RD_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .core_wen(wen), .core_mode(mode), .core_addr(addr),
    .core_wdata(wdata), .core_rdata(rdata1), .core_ready(ready1), .misalign_err(mis1),
    .sram_ce(ce1), .sram_we(we1), .sram_be(be1), .sram_addr(saddr1),
    .sram_wdata(swdata1), .sram_rdata(srdata1)
  );

  mem_ctrl #(.ADDR_WIDTH(16), .RD_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst), .core_wen(wen), .core_mode(mode), .core_addr(addr),
    .core_wdata(wdata), .core_rdata(rdata3), .core_ready(ready3), .misalign_err(mis3),
    .sram_ce(ce3), .sram_we(we3), .sram_be(be3), .sram_addr(saddr3),
    .sram_wdata(swdata3), .sram_rdata(srdata3)
  );

  // Behavioural SRAM: byte-lane writes, fixed-latency registered reads.
  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    for (int b = 0; b < 4; b++) begin
      if (ce1 && we1 && be1[b]) mem[saddr1[7:0]][b*8 +: 8] <= swdata1[b*8 +: 8];
      if (ce3 && we3 && be3[b]) mem[saddr3[7:0]][b*8 +: 8] <= swdata3[b*8 +: 8];
    end
    srdata1  <= mem[saddr1[7:0]];
    pipe3[0] <= mem[saddr3[7:0]];
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
    if (ce1 === 1'b1) ce_cnt1 <= ce_cnt1 + 1;
    if (ce3 === 1'b1) ce_cnt3 <= ce_cnt3 + 1;
  end
  assign srdata3 = pipe3[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; wen = 1'b0; mode = 3'b000; addr = '0; wdata = '0;
    pl_en = 1'b0; pl_idx = '0; pl_val = '0;
    #2;
    check("rst ce", 32'(ce1), 32'd0);
    check("rst ready", 32'(ready1), 32'd0);
    check("rst rdata", rdata1, 32'd0);
    check("rst mis", 32'(mis1), 32'd0);
    check("rst be", 32'(be1), 32'd0);
    check("rst we", 32'(we1), 32'd0);
    check("rst wdata", swdata1, 32'd0);
    check("rst addr", 32'(saddr1), 32'd0);

    pl_en = 1'b1; pl_idx = 8'd4; pl_val = 32'hDEADBEEF;
    tick();
    pl_idx = 8'd5; pl_val = 32'h12345678;
    tick();
    pl_en = 1'b0;
    rst = 1'b1;
    repeat (10) tick();

    // Word fetch, latency 1
    mode = 3'b111; addr = 32'h10;
    #1;
    n0 = ce_cnt1;
    check("fetch ce", 32'(ce1), 32'd1);
    check("fetch be", 32'(be1), 32'hF);
    check("fetch addr", 32'(saddr1), 32'd4);
    check("fetch we", 32'(we1), 32'd0);
    check("fetch ready drop", 32'(ready1), 32'd0);
    tick(); tick();
    check("fetch ready early", 32'(ready1), 32'd0);
    tick();
    check("fetch ready", 32'(ready1), 32'd1);
    check("fetch rdata", rdata1, 32'hDEADBEEF);
    check("fetch ce count", 32'(ce_cnt1 - n0), 32'd1);

    // Signed / unsigned byte loads
    pl_en = 1'b1; pl_idx = 8'd4; pl_val = 32'h80FF0000;
    tick();
    pl_en = 1'b0;
    mode = 3'b000; addr = 32'h13;
    #1;
    check("lb ce", 32'(ce1), 32'd1);
    repeat (3) tick();
    check("lb ready", 32'(ready1), 32'd1);
    check("lb rdata", rdata1, 32'hFFFFFF80);
    mode = 3'b100;
    #1;
    check("lbu ce", 32'(ce1), 32'd1);
    check("lbu ready drop", 32'(ready1), 32'd0);
    repeat (3) tick();
    check("lbu ready", 32'(ready1), 32'd1);
    check("lbu rdata", rdata1, 32'h00000080);

    // Store half, held 10 cycles
    wen = 1'b1; mode = 3'b001; addr = 32'h22; wdata = 32'h0000ABCD;
    #1;
    n0 = ce_cnt1;
    check("sh ce", 32'(ce1), 32'd1);
    check("sh we", 32'(we1), 32'd1);
    check("sh be", 32'(be1), 32'hC);
    check("sh wdata", swdata1, 32'hABCDABCD);
    check("sh addr", 32'(saddr1), 32'd8);
    tick();
    check("sh ready early", 32'(ready1), 32'd0);
    tick();
    check("sh ready", 32'(ready1), 32'd1);
    repeat (8) tick();
    check("sh ce count", 32'(ce_cnt1 - n0), 32'd1);
    check("sh mem", 32'(mem[8][31:16]), 32'h0000ABCD);

    // Misaligned word load, then aligned
    wen = 1'b0; wdata = '0; mode = 3'b010; addr = 32'h6;
    #1;
    n0 = ce_cnt1;
    check("mis ce", 32'(ce1), 32'd0);
    tick();
    check("mis err", 32'(mis1), 32'd1);
    check("mis ready early", 32'(ready1), 32'd0);
    tick();
    check("mis ready", 32'(ready1), 32'd1);
    check("mis rdata", rdata1, 32'd0);
    check("mis ce count", 32'(ce_cnt1 - n0), 32'd0);
    addr = 32'h10;
    #1;
    check("align ce", 32'(ce1), 32'd1);
    tick();
    check("align clr", 32'(mis1), 32'd0);
    tick(); tick();
    check("align ready", 32'(ready1), 32'd1);
    check("align rdata", rdata1, 32'h80FF0000);

    // Latency 3 with a change one cycle into the access
    repeat (10) tick();
    mode = 3'b111; addr = 32'h10;
    #1;
    n0 = ce_cnt3;
    tick();
    addr = 32'h14;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("lat3 masked", 32'(ready3), 32'd0);
    end
    tick();
    check("lat3 ready", 32'(ready3), 32'd1);
    check("lat3 rdata", rdata3, 32'h12345678);
    check("lat3 ce count", 32'(ce_cnt3 - n0), 32'd2);

    // Async reset mid-WAIT
    addr = 32'h10;
    #1;
    tick();
    rst = 1'b0;
    #1;
    check("arst ce", 32'(ce3), 32'd0);
    check("arst ready", 32'(ready3), 32'd0);
    check("arst rdata", rdata3, 32'd0);
    check("arst mis", 32'(mis3), 32'd0);
    check("arst be", 32'(be3), 32'd0);
    check("arst addr", 32'(saddr3), 32'd0);
    tick();
    rst = 1'b1;
    #1;
    check("rel ce", 32'(ce3), 32'd1);
    check("rel addr", 32'(saddr3), 32'd4);
    repeat (5) tick();
    check("rel ready", 32'(ready3), 32'd1);
    check("rel rdata", rdata3, 32'h80FF0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
